// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: shift-and-add 32x32 multiply (low 32 bits) driving the shared ALU one op per cycle
module alu_mul_sequencer #(
   parameter logic [3:0] OP_ADD = 4'b0001,
   parameter logic [3:0] OP_SHL = 4'b0011,
   parameter logic [3:0] OP_SHR = 4'b0100,
   parameter logic [3:0] OP_NOP = 4'b0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] a_in,
   input  logic [31:0] b_in,
   output logic        busy,
   output logic        done,
   output logic [31:0] product,
   output logic [5:0]  iterations,
   output logic [3:0]  alu_op,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   input  logic [31:0] alu_result,
   input  logic        alu_zero
);
   typedef enum logic [2:0] {S_IDLE, S_ADD, S_SHL, S_SHR, S_DONE} state_t;
   state_t      state_q, state_d;
   logic [31:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d, product_q, product_d;
   logic [5:0]  iter_q, iter_d;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         product_q <= '0;
         iter_q    <= '0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         acc_q     <= acc_d;
         product_q <= product_d;
         iter_q    <= iter_d;
      end
   end
   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      acc_d     = acc_q;
      product_d = product_q;
      iter_d    = iter_q;
      case (state_q)
         S_IDLE: if (start) begin
            state_d  = S_ADD;
            mcand_d  = a_in;
            mplier_d = b_in;
            acc_d    = '0;
            iter_d   = '0;
         end
         S_ADD: begin
            acc_d   = alu_result;
            state_d = S_SHL;
         end
         S_SHL: begin
            mcand_d = alu_result;
            state_d = S_SHR;
         end
         S_SHR: begin
            mplier_d  = alu_result;
            iter_d    = iter_q + 6'd1;
            state_d   = alu_zero ? S_DONE : S_ADD;
            product_d = alu_zero ? acc_q : product_q;
         end
         default: state_d = S_IDLE;
      endcase
   end
   // ALU operands are purely a function of state and registers
   always_comb begin
      busy   = state_q == S_ADD || state_q == S_SHL || state_q == S_SHR;
      done   = state_q == S_DONE;
      alu_op = state_q == S_ADD ? OP_ADD : state_q == S_SHL ? OP_SHL : state_q == S_SHR ? OP_SHR : OP_NOP;
      alu_a  = state_q == S_ADD ? acc_q : state_q == S_SHL ? mcand_q : state_q == S_SHR ? mplier_q : '0;
      alu_b  = state_q == S_ADD ? (mplier_q[0] ? mcand_q : '0) :
               (state_q == S_SHL || state_q == S_SHR) ? 32'd1 : '0;
   end
   assign product    = product_q;
   assign iterations = iter_q;
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb_alu_mul_sequencer: directed vectors against a behavioural ALU
module tb_alu_mul_sequencer;
   logic        clk = 0, reset = 1, start = 0;
   logic [31:0] a_in = 0, b_in = 0;
   logic        busy, done;
   logic [31:0] product, alu_a, alu_b, alu_result;
   logic [5:0]  iterations;
   logic [3:0]  alu_op;
   logic        alu_zero;
   int          errors = 0, checks = 0;
   logic [3:0]  tr_op [0:95];
   logic [31:0] tr_a [0:95], tr_b [0:95];
   bit          hold = 0, swap = 0;
   logic [31:0] sa, sb;
   int          cyc, busy_n;

   alu_mul_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .a_in(a_in), .b_in(b_in),
      .busy(busy), .done(done), .product(product), .iterations(iterations),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_result(alu_result), .alu_zero(alu_zero)
   );

   assign alu_result = alu_op == 4'b0001 ? alu_a + alu_b :
                       alu_op == 4'b0011 ? alu_a << alu_b :
                       alu_op == 4'b0100 ? alu_a >> alu_b : 32'd0;
   assign alu_zero = alu_result == 32'd0;

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic go(input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      a_in  = a;
      b_in  = b;
      start = 1;
   endtask

   task automatic wait_done();
      cyc    = -1;
      busy_n = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (!hold) start = 0;
         if (swap && cyc == 1) begin
            a_in = sa;
            b_in = sb;
         end
         if (busy) begin
            busy_n++;
            if (cyc < 96) begin
               tr_op[cyc] = alu_op;
               tr_a[cyc]  = alu_a;
               tr_b[cyc]  = alu_b;
            end
         end
      end while (!done && cyc < 200);
   endtask

   task automatic check_run(input string tag, input logic [31:0] exp_p, input int k);
      int bad;
      logic [3:0] pat [0:2];
      pat = '{4'b0001, 4'b0011, 4'b0100};
      bad = 0;
      check({tag, "_done"}, done, 1);
      check({tag, "_latency"}, cyc, 3 * k);
      check({tag, "_busy_cycles"}, busy_n, 3 * k);
      check({tag, "_product"}, product, exp_p);
      check({tag, "_iterations"}, iterations, k);
      check({tag, "_done_op"}, alu_op, 4'b0000);
      for (int j = 0; j < 3 * k && j < 96; j++) if (tr_op[j] !== pat[j % 3]) bad++;
      check({tag, "_op_trace_bad"}, bad, 0);
      @(negedge clk);
      check({tag, "_done_pulse"}, done, 0);
      check({tag, "_idle_busy"}, busy, 0);
      check({tag, "_product_held"}, product, exp_p);
   endtask

   initial begin
      #12;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_product", product, 0);
      check("rst_iter", iterations, 0);
      check("rst_op", alu_op, 0);
      check("rst_alu_a", alu_a, 0);
      check("rst_alu_b", alu_b, 0);
      @(negedge clk);
      reset = 0;

      go(32'd7, 32'd6);
      wait_done();
      check_run("t7x6", 32'd42, 3);
      check("t7x6_add0_a", tr_a[0], 0);
      check("t7x6_add0_b", tr_b[0], 0);
      check("t7x6_shl_a", tr_a[1], 7);
      check("t7x6_shl_b", tr_b[1], 1);
      check("t7x6_shr_a", tr_a[2], 6);
      check("t7x6_add1_b", tr_b[3], 14);

      go(32'hFFFF_FFFF, 32'd0);
      wait_done();
      check_run("tbzero", 32'd0, 1);

      go(32'h0001_0000, 32'h0001_0001);
      wait_done();
      check_run("twrap", 32'h0001_0000, 17);

      go(32'd3, 32'h8000_0000);
      wait_done();
      check_run("tmsb", 32'h8000_0000, 32);

      go(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done();
      check_run("tones", 32'h0000_0001, 32);

      hold = 1;
      swap = 1;
      sa   = 32'd9;
      sb   = 32'd1;
      go(32'd2, 32'd3);
      wait_done();
      swap = 0;
      check_run("thold1", 32'd6, 2);
      hold = 0;
      wait_done();
      check_run("thold2", 32'd9, 1);

      go(32'd1234, 32'h0000_FFFF);
      for (int j = 0; j < 5; j++) begin
         @(negedge clk);
         start = 0;
      end
      check("rst_mid_op", alu_op, 4'b0011);
      check("rst_mid_iter", iterations, 1);
      reset = 1;
      #1;
      check("rst_mid_busy", busy, 0);
      check("rst_mid_done", done, 0);
      check("rst_mid_product", product, 0);
      check("rst_mid_iterations", iterations, 0);
      check("rst_mid_aluop", alu_op, 0);
      @(negedge clk);
      reset = 0;
      go(32'd5, 32'd5);
      wait_done();
      check_run("t5x5", 32'd25, 3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
